// File: rtl/gpio_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one GPIO slave between NM masters; 1-cycle arbitration latency.
// Grant is held for the whole cyc; non-granted masters stall; a hung slave is converted into err after TIMEOUT cycles.
module gpio_wb_arbiter #(
    parameter int NM      = 2,
    parameter int AW      = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*4-1:0]  m_sel_i,
    output logic [DW-1:0]    m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [3:0]       s_sel_o,
    input  logic [DW-1:0]    s_dat_i,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    output logic [NM-1:0]    grant_o
);

    localparam int LW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [NM-1:0]   grant_nxt;
    logic [LW-1:0]   last_grant, last_nxt;
    logic            req_stb;
    logic            tmo_hit;
    logic            timeout_err;

    assign m_dat_o = s_dat_i;

    // last_grant doubles as the index of the current owner while in GRANT
    assign req_stb = (state == GRANT) && m_cyc_i[last_grant] && m_stb_i[last_grant];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= LW'(NM - 1);
        end else begin
            state      <= state_nxt;
            grant_o    <= grant_nxt;
            last_grant <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        last_nxt  = last_grant;
        case (state)
            IDLE: begin
                if (|m_cyc_i) begin
                    for (int k = NM; k >= 1; k--) begin
                        // scanning downward lets the nearest requester after last_grant win
                        if (m_cyc_i[(int'(last_grant) + k) % NM]) begin
                            last_nxt  = LW'((int'(last_grant) + k) % NM);
                            grant_nxt = '0;
                            grant_nxt[(int'(last_grant) + k) % NM] = 1'b1;
                        end
                    end
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!m_cyc_i[last_grant]) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (state == GRANT) begin
            s_cyc_o = m_cyc_i[last_grant];
            // stb is masked on the timeout cycle independent of ack to avoid a loop through a combinational slave
            s_stb_o = req_stb && !tmo_hit;
            s_we_o  = m_we_i[last_grant];
            s_adr_o = m_adr_i[int'(last_grant)*AW +: AW];
            s_dat_o = m_dat_i[int'(last_grant)*DW +: DW];
            s_sel_o = m_sel_i[int'(last_grant)*4 +: 4];
            m_ack_o[last_grant] = s_ack_i;
            m_err_o[last_grant] = s_err_i | timeout_err;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_tmo
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] tmo_cnt;

            assign tmo_hit     = req_stb && (tmo_cnt == CW'(TIMEOUT - 1));
            assign timeout_err = tmo_hit && !s_ack_i && !s_err_i;

            always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
                if (wb_rst_i) begin
                    tmo_cnt <= '0;
                end else if (!req_stb || s_ack_i || s_err_i || tmo_hit) begin
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end else begin : g_no_tmo
            assign tmo_hit     = 1'b0;
            assign timeout_err = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Directed bench for gpio_wb_arbiter (NM=2, TIMEOUT=4) with a scoreboard of expected slave-side beats.
module tb_gpio_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*4-1:0]   m_sel;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
    logic              s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o, s_dat_i;
    logic [3:0]        s_sel_o;
    logic              s_ack_i, s_err_i;
    logic              ack_en, ack_force, err_force;

    typedef struct {
        int         m;
        logic       we;
        logic [3:0] adr;
        logic [31:0] dat;
        logic [3:0] sel;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign s_dat_i = {28'hDA7A000, s_adr_o};
    assign s_ack_i = ack_en ? (s_cyc_o & s_stb_o) : ack_force;
    assign s_err_i = err_force;

    gpio_wb_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .grant_o  (grant_o)
    );

    function automatic logic [31:0] rd_model(logic [3:0] a);
        return 32'hDA7A_0000 | {28'd0, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_m(int i, logic cyc, logic stb, logic we, logic [3:0] adr,
                         logic [31:0] dat, logic [3:0] sel);
        m_cyc[i] = cyc;
        m_stb[i] = stb;
        m_we[i]  = we;
        m_adr[i*AW +: AW] = adr;
        m_dat[i*DW +: DW] = dat;
        m_sel[i*4 +: 4]   = sel;
    endtask

    task automatic req(int i, logic we, logic [3:0] adr, logic [31:0] dat, logic [3:0] sel, bit expect_beat);
        exp_t e;
        set_m(i, 1'b1, 1'b1, we, adr, dat, sel);
        if (expect_beat) begin
            e.m = i; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
            sb.push_back(e);
        end
    endtask

    task automatic idle_m(int i);
        set_m(i, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for the DUT to ack, then pop and compare the oldest expected beat
    task automatic beat(string tag);
        exp_t e;
        int n = 0;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        while (m_ack_o == '0 && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_ack"},   32'(m_ack_o), 32'(1 << e.m));
        chk({tag, "_grant"}, 32'(grant_o), 32'(1 << e.m));
        chk({tag, "_adr"},   32'(s_adr_o), 32'(e.adr));
        chk({tag, "_we"},    32'(s_we_o),  32'(e.we));
        chk({tag, "_sel"},   32'(s_sel_o), 32'(e.sel));
        if (e.we) chk({tag, "_wdat"}, s_dat_o, e.dat);
        else      chk({tag, "_rdat"}, m_dat_o, rd_model(e.adr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        ack_en = 1'b1; ack_force = 1'b0; err_force = 1'b0;
        #1;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_scyc",  32'(s_cyc_o), 32'd0);
        chk("rst_sstb",  32'(s_stb_o), 32'd0);
        chk("rst_ack",   32'(m_ack_o), 32'd0);
        chk("rst_err",   32'(m_err_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single write from master0
        req(0, 1'b1, 4'd4, 32'h00A5_5A00, 4'b0110, 1'b1);
        #1;
        chk("t1_idle_scyc", 32'(s_cyc_o), 32'd0);
        tick();
        beat("t1");
        idle_m(0);
        #1;
        chk("t1_rel_scyc",  32'(s_cyc_o), 32'd0);
        chk("t1_rel_grant", 32'(grant_o), 32'd1);
        tick();
        chk("t1_idle_grant", 32'(grant_o), 32'd0);

        // Contention straight after reset, then round-robin
        do_reset();
        req(0, 1'b1, 4'd1, 32'h1111_1111, 4'hF, 1'b1);
        req(1, 1'b0, 4'd2, 32'h0, 4'hF, 1'b1);
        tick();
        beat("t2_m0");
        idle_m(0);
        tick();
        chk("t2_gap_grant", 32'(grant_o), 32'd0);
        chk("t2_gap_ack",   32'(m_ack_o), 32'd0);
        chk("t2_gap_scyc",  32'(s_cyc_o), 32'd0);
        tick();
        beat("t2_m1");
        idle_m(1);
        tick();
        req(0, 1'b1, 4'd5, 32'h5555_0005, 4'h3, 1'b1);
        req(1, 1'b0, 4'd6, 32'h0, 4'hF, 1'b0);
        tick();
        beat("t2_rr");
        idle_m(0);
        idle_m(1);
        tick();

        // Burst of three reads from master1 while master0 waits
        req(1, 1'b0, 4'd0, 32'h0, 4'hF, 1'b1);
        req(0, 1'b1, 4'd7, 32'hDEAD_BEEF, 4'h3, 1'b0);
        for (int b = 1; b < 3; b++) begin
            exp_t e;
            e.m = 1; e.we = 1'b0; e.adr = 4'(b * 4); e.dat = 32'h0; e.sel = 4'hF;
            sb.push_back(e);
        end
        begin
            exp_t e;
            e.m = 0; e.we = 1'b1; e.adr = 4'd7; e.dat = 32'hDEAD_BEEF; e.sel = 4'h3;
            sb.push_back(e);
        end
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b > 0) begin
                set_m(1, 1'b1, 1'b1, 1'b0, 4'(b * 4), 32'h0, 4'hF);
                tick();
            end
            beat("t3_burst");
        end
        idle_m(1);
        tick();
        chk("t3_gap_grant", 32'(grant_o), 32'd0);
        tick();
        beat("t3_m0");
        idle_m(0);
        tick();

        // Timeout with a silent slave; err pulses every 4th stb cycle
        do_reset();
        ack_en = 1'b0;
        set_m(0, 1'b1, 1'b1, 1'b0, 4'd3, 32'h0, 4'hF);
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("t4_err",  32'(m_err_o), (c % 4 == 0) ? 32'd1 : 32'd0);
            chk("t4_sstb", 32'(s_stb_o), (c % 4 == 0) ? 32'd0 : 32'd1);
            if (c < 8) tick();
        end
        idle_m(0);
        tick();

        // Ack lands on the timeout cycle; then ack and err together
        set_m(0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h0, 4'hF);
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk("t5_pre_err", 32'(m_err_o), 32'd0);
            tick();
        end
        ack_force = 1'b1;
        #1;
        chk("t5_race_ack", 32'(m_ack_o), 32'd1);
        chk("t5_race_err", 32'(m_err_o), 32'd0);
        chk("t5_race_dat", m_dat_o, rd_model(4'd9));
        tick();
        err_force = 1'b1;
        #1;
        chk("t5_both_ack", 32'(m_ack_o), 32'd1);
        chk("t5_both_err", 32'(m_err_o), 32'd1);
        ack_force = 1'b0;
        err_force = 1'b0;
        idle_m(0);
        tick();

        // Asynchronous reset while master1 owns the bus
        set_m(1, 1'b1, 1'b1, 1'b0, 4'd2, 32'h0, 4'hF);
        tick();
        chk("t6_pre_grant", 32'(grant_o), 32'd2);
        chk("t6_pre_sstb",  32'(s_stb_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_scyc",  32'(s_cyc_o), 32'd0);
        chk("t6_rst_sstb",  32'(s_stb_o), 32'd0);
        chk("t6_rst_grant", 32'(grant_o), 32'd0);
        chk("t6_rst_ack",   32'(m_ack_o), 32'd0);
        chk("t6_rst_err",   32'(m_err_o), 32'd0);
        rst = 1'b0;
        ack_en = 1'b1;
        req(0, 1'b0, 4'd1, 32'h0, 4'hF, 1'b1);
        tick();
        beat("t6_m0");
        idle_m(0);
        idle_m(1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
